// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data bits
// LSB first, optional parity and one stop bit, on a registered, idle-high tx pin.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BODE_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_ctrl,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BODE_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ / BODE_RATE must be at least 2");
        end
    endgenerate

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       data_q;
    logic [1:0]       ctrl_q;
    logic             bit_end;

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign tx_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            // Every non-idle state lasts exactly one bit period; the counter wraps on its last cycle.
            if (state != S_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_data_valid) begin
                        data_q   <= tx_data;
                        ctrl_q   <= tx_ctrl;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx    <= data_q[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            if (ctrl_q[0]) begin
                                tx    <= (^data_q) ^ ctrl_q[1];
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= data_q[bit_idx + 3'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter and the transmit-side counterpart of `uart_rx`, sharing its baud parameters and its 2-bit frame-control encoding. It accepts one byte per valid/ready handshake from the core-side bus, frames it as start, 8 data bits LSB first, optional parity and one stop bit, and drives the `tx` pin. It sits between the memory-mapped UART register block and the board TX pin.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BODE_RATE`, default 115_200: baud rate in bit/s.
- Derived: `CLKS_PER_BIT = CLK_FREQ / BODE_RATE`, using integer division (truncation). Elaboration must fail if the result is below 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_data_valid`  in  1  the producer offers `tx_data` / `tx_ctrl`.
- `tx_data`  in  8  byte to send.
- `tx_ctrl`  in  2  frame control:
  - bit0 = parity enable.
  - bit1 = parity type: 1 is odd, 0 is even.
  - Same encoding as `rx_ctrl`.
- `tx_ready`  out  1  the transmitter can accept a byte.
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.
- `tx`  out  1  serial line; registered output; idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- A baud counter counts 0..CLKS_PER_BIT-1 and a bit index counts 0..7.
- `tx_ready` is `(state == IDLE) && !rst`. It is combinational from state.
- Handshake: a transfer occurs on a rising edge where `tx_data_valid && tx_ready`. On that edge:
  - `tx_data` and `tx_ctrl` are latched into shadow registers.
  - The state moves to START and `tx` is driven 0.
  - Later changes to the inputs have no effect on the frame in flight.
- START: holds `tx` = 0 for CLKS_PER_BIT cycles, then moves to DATA.
- DATA: sends bits 0..7, LSB first, each for CLKS_PER_BIT cycles. After bit 7:
  - moves to PARITY if latched ctrl bit0 = 1;
  - otherwise moves to STOP.
- PARITY: sends `^data ^ ctrl[1]` for CLKS_PER_BIT cycles. This gives even parity for ctrl[1] = 0 and odd parity for ctrl[1] = 1.
- STOP: holds `tx` = 1 for CLKS_PER_BIT cycles. On its last edge the state moves to IDLE and `tx_done` = 1 for exactly one cycle.
- IDLE: `tx` = 1 and `tx_data_valid` is ignored unless `tx_ready` = 1.
- Frame length is B bits, where B = 10 without parity and B = 11 with parity.
- Reset values, applied on any edge with `rst` = 1:
  - state = IDLE, `tx` = 1, `tx_done` = 0.
  - Counters and shadow registers are cleared.
  - `tx_ready` = 0 while `rst` is high and 1 on the first cycle after it drops.
- Reset mid-frame aborts the frame. `tx` returns to 1 on that edge, no `tx_done` pulse is produced, and the byte is discarded.
- `tx_data_valid` asserted during reset is not accepted.

## Timing
- Let edge E0 be the acceptance edge. Bit k (start is k = 0) occupies cycles [E0 + k·N, E0 + (k+1)·N), where N = CLKS_PER_BIT.
- The `tx` transition is visible one clock after E0. There is no combinational path from the inputs to `tx`.
- At edge E0 + B·N:
  - `tx` stays 1;
  - `tx_done` rises and falls on the next edge;
  - `tx_ready` goes to 1.
- Back-to-back transfers with `tx_data_valid` held high: the next acceptance is at E0 + B·N + 1. The effective stop time is therefore N + 1 cycles, and the throughput is one frame per B·N + 1 cycles.
- `tx_done` and `tx_ready` are high in the same cycle, so a producer may present the next byte in the cycle after `tx_done`.
- `tx_ready` is never high during START, DATA, PARITY or STOP.

## Test plan
All scenarios use CLK_FREQ = 100_000_000, BODE_RATE = 10_000_000 (N = 10) and a 10 ns clock.
- Reset: hold `rst` high for 2 cycles while `tx_data_valid` = 1 and `tx_data` = 0xFF → `tx` = 1, `tx_done` = 0, `tx_ready` = 0 during reset. After `rst` drops, `tx_ready` = 1 and no frame starts until `valid` is sampled with `ready` high.
- Frame 0x55, ctrl 00 → `tx` reads 0,1,0,1,0,1,0,1,0,1, each bit 100 ns.
  - `tx_ready` is low for exactly 100 cycles.
  - `tx_done` pulses for 1 cycle at E0 + 100.
- Parity: 0x33 with ctrl 01 (even) gives parity bit 0; 0xF0 with ctrl 11 (odd) gives parity bit 1; 0x26 with ctrl 11 gives parity bit 0.
  - Each frame is 110 cycles.
  - Looping `tx` into `uart_rx` with the same ctrl yields `rx_data` equal to the sent byte with no parity error.
- Back-to-back: hold `valid` with 0xA5, then switch `tx_data` to 0x3C on the `tx_done` cycle → the second start bit begins 101 cycles after the first.
  - Both bytes are received correctly.
  - `tx_ready` is high for exactly 1 cycle between frames.
- Input stability: change `tx_data` and `tx_ctrl` every cycle during a 0x0F / ctrl 01 frame → the serial output still matches 0x0F with even parity bit 0.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 3 → `tx` = 1 on the next cycle, no `tx_done` pulse, `tx_ready` = 1 one cycle after `rst` drops, and the next byte 0x81 is transmitted cleanly.
